// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store sequencer: op codes, FSM states,
// access sizes and small decode helpers.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic mem_size_e op_size(input mem_op_e op);
        mem_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extends load lanes, merges store lanes into
// the current RAM word and flags misaligned accesses.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_word,
    output logic [31:0] merge_word,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = ram_rdata[7:0];
            2'd1:    byte_lane = ram_rdata[15:8];
            2'd2:    byte_lane = ram_rdata[23:16];
            default: byte_lane = ram_rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    end

    always_comb begin
        load_word = '0;
        case (op)
            OP_LB:   load_word = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  load_word = {24'd0, byte_lane};
            OP_LH:   load_word = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_word = {16'd0, half_lane};
            OP_LW:   load_word = ram_rdata;
            default: load_word = '0;
        endcase
    end

    always_comb begin
        merge_word = ram_rdata;
        case (op)
            OP_SB: begin
                case (addr_lo)
                    2'd0:    merge_word[7:0]   = wdata[7:0];
                    2'd1:    merge_word[15:8]  = wdata[7:0];
                    2'd2:    merge_word[23:16] = wdata[7:0];
                    default: merge_word[31:24] = wdata[7:0];
                endcase
            end
            OP_SH: begin
                if (addr_lo[1]) merge_word[31:16] = wdata[15:0];
                else            merge_word[15:0]  = wdata[15:0];
            end
            OP_SW:   merge_word = wdata;
            default: merge_word = ram_rdata;
        endcase
    end

    always_comb begin
        case (op_size(op))
            SZ_HALF: misaligned = addr_lo[0];
            SZ_WORD: misaligned = (addr_lo != 2'd0);
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-wide, combinational-
// read data RAM; sub-word stores are done as read-merge-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter logic [31:0] ADDRESS_INITIAL = 32'h0000_0000,
    parameter logic [31:0] MEM_BYTES       = 32'h0004_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_adel,
    output logic        resp_ades,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    mau_state_e  state_q, state_d;
    mem_op_e     op_q;
    mem_op_e     req_op_e;
    logic [31:0] addr_q, wdata_q, merge_q;
    logic [31:0] rdata_q;
    logic        adel_q, ades_q;

    mem_op_e     lane_op;
    logic [1:0]  lane_addr;
    logic [31:0] load_word, merge_word;
    logic        misaligned;

    logic [31:0] req_offset;
    logic        out_of_range, req_fault;

    logic        accept, merge_load, resp_load;
    logic [31:0] resp_rdata_d;
    logic        adel_d, ades_d;

    assign req_op_e = mem_op_e'(req_op);

    // One lane aligner serves both the acceptance check (IDLE, live request)
    // and the data path (ACCESS, latched request).
    always_comb begin
        if (state_q == ST_IDLE) begin
            lane_op   = req_op_e;
            lane_addr = req_addr[1:0];
        end else begin
            lane_op   = op_q;
            lane_addr = addr_q[1:0];
        end
    end

    mem_lane_align u_lane (
        .op         (lane_op),
        .addr_lo    (lane_addr),
        .ram_rdata  (ram_rdata),
        .wdata      (wdata_q),
        .load_word  (load_word),
        .merge_word (merge_word),
        .misaligned (misaligned)
    );

    // Unsigned wrap makes addresses below the base fault as well.
    assign req_offset   = req_addr - ADDRESS_INITIAL;
    assign out_of_range = (req_offset >= MEM_BYTES);
    assign req_fault    = misaligned || out_of_range;

    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        ram_we       = 1'b0;
        ram_wdata    = merge_q;
        accept       = 1'b0;
        merge_load   = 1'b0;
        resp_load    = 1'b0;
        resp_rdata_d = '0;
        adel_d       = 1'b0;
        ades_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_fault) begin
                        resp_load = 1'b1;
                        adel_d    = !is_store(req_op_e);
                        ades_d    = is_store(req_op_e);
                        state_d   = ST_RESP;
                    end else begin
                        state_d   = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (!is_store(op_q)) begin
                    resp_load    = 1'b1;
                    resp_rdata_d = load_word;
                    state_d      = ST_RESP;
                end else if (op_q == OP_SW) begin
                    ram_we    = 1'b1;
                    ram_wdata = wdata_q;
                    resp_load = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    merge_load = 1'b1;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_we    = 1'b1;
                ram_wdata = merge_q;
                resp_load = 1'b1;
                state_d   = ST_RESP;
            end
            default: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_LB;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op_e;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (merge_load) merge_q <= merge_word;
            if (resp_load) begin
                rdata_q <= resp_rdata_d;
                adel_q  <= adel_d;
                ades_q  <= ades_d;
            end
        end
    end

    assign ram_addr   = {addr_q[31:2], 2'b00};
    assign resp_rdata = rdata_q;
    assign resp_adel  = adel_q;
    assign resp_ades  = ades_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random
// traffic compared against an arithmetic memory model.
module tb_mem_access_unit;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] BYTES = 32'h0004_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_adel, resp_ades;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(
        .ADDRESS_INITIAL (BASE),
        .MEM_BYTES       (BYTES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_adel  (resp_adel),
        .resp_ades  (resp_ades),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Stand-in data RAM: words never written read back a fixed pattern.
    logic [31:0] ram [0:65535];
    bit          written [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_idx = '0;
    logic [31:0] poke_val = '0;

    function automatic logic [31:0] init_val(input int unsigned i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ram_word(input logic [15:0] i);
        return written[i] ? ram[i] : init_val(32'(i));
    endfunction

    assign ram_rdata = ram_word(ram_addr[17:2]);

    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr[17:2]]     <= ram_wdata;
            written[ram_addr[17:2]] <= 1'b1;
        end else if (poke_en) begin
            ram[poke_idx]     <= poke_val;
            written[poke_idx] <= 1'b1;
        end
    end

    logic [31:0] ref_mem [0:65535];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Reference behaviour from the byte-addressed rules, not the FSM.
    function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata,
                                  output logic exp_adel, output logic exp_ades,
                                  output logic [31:0] exp_rdata, output int exp_lat,
                                  output int exp_nwe, output logic [31:0] exp_wword);
        int unsigned size, sh;
        bit          store, signed_ld;
        logic [31:0] off, word, mask;
        store     = (op >= 3'd5);
        signed_ld = (op == 3'd0) || (op == 3'd2);
        case (op)
            3'd0, 3'd1, 3'd5: size = 1;
            3'd2, 3'd3, 3'd6: size = 2;
            default:          size = 4;
        endcase
        off = addr - BASE;
        exp_rdata = '0; exp_wword = '0; exp_nwe = 0; exp_adel = 1'b0; exp_ades = 1'b0;
        if (off >= BYTES || (addr % size) != 0) begin
            exp_adel = !store;
            exp_ades = store;
            exp_lat  = 1;
            return;
        end
        word = ref_mem[off[17:2]];
        sh   = 8 * (addr % 4);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        if (!store) begin
            exp_rdata = (word >> sh) & mask;
            if (signed_ld && exp_rdata[8*size-1]) exp_rdata = exp_rdata | ~mask;
            exp_lat = 2;
        end else begin
            exp_wword = (word & ~(mask << sh)) | ((wdata & mask) << sh);
            ref_mem[off[17:2]] = exp_wword;
            exp_nwe = 1;
            exp_lat = (size == 4) ? 2 : 3;
        end
    endfunction

    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_rdata, output logic got_adel, output logic got_ades);
        logic        e_adel, e_ades;
        logic [31:0] e_rdata, e_wword, got_wword, got_waddr;
        int          e_lat, e_nwe, lat, nwe;
        model(op, addr, wdata, e_adel, e_ades, e_rdata, e_lat, e_nwe, e_wword);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0; nwe = 0; got_wword = '0; got_waddr = '0;
        do begin
            @(negedge clk);
            lat++;
            if (ram_we) begin
                nwe++;
                got_wword = ram_wdata;
                got_waddr = ram_addr;
            end
        end while (!resp_valid && lat < 10);
        got_rdata = resp_rdata; got_adel = resp_adel; got_ades = resp_ades;
        check("latency", 32'(lat), 32'(e_lat));
        check("resp_rdata", got_rdata, e_rdata);
        check("resp_adel", 32'(got_adel), 32'(e_adel));
        check("resp_ades", 32'(got_ades), 32'(e_ades));
        check("we_pulses", 32'(nwe), 32'(e_nwe));
        if (e_nwe == 1) begin
            check("write_word", got_wword, e_wword);
            check("write_addr", got_waddr, addr & ~32'h3);
        end
        @(negedge clk);
        check("resp_pulse_end", 32'(resp_valid), 32'd0);
        check("resp_rdata_hold", resp_rdata, e_rdata);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        check({tag, "_adel"}, 32'(resp_adel), 32'd0);
        check({tag, "_ades"}, 32'(resp_ades), 32'd0);
        check({tag, "_we"}, 32'(ram_we), 32'd0);
        check({tag, "_addr"}, ram_addr, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, r1, r2;
        logic        adel, ades;
        logic [7:0]  rv_seen, rdy_seen;
        logic        e_adel, e_ades;
        logic [31:0] e1, e2, e_w;
        int          e_lat, e_nwe, bad;
        logic [2:0]  op;
        logic [31:0] addr;
        int unsigned sel;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(32'(i));

        repeat (2) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        #1 check_reset_outputs("after_reset");

        poke(16'd4, 32'hDEAD_BEEF);
        do_req(3'd4, 32'h10, 32'h0, r, adel, ades);
        check("lw_word", r, 32'hDEAD_BEEF);

        poke(16'd4, 32'h8011_2233);
        do_req(3'd0, 32'h13, 32'h0, r, adel, ades);
        check("lb_sign", r, 32'hFFFF_FF80);
        do_req(3'd1, 32'h13, 32'h0, r, adel, ades);
        check("lbu_zero", r, 32'h0000_0080);
        do_req(3'd2, 32'h12, 32'h0, r, adel, ades);
        check("lh_sign", r, 32'hFFFF_8011);
        do_req(3'd3, 32'h12, 32'h0, r, adel, ades);
        check("lhu_zero", r, 32'h0000_8011);

        poke(16'd8, 32'h1122_3344);
        do_req(3'd5, 32'h21, 32'h0000_00AB, r, adel, ades);
        do_req(3'd4, 32'h20, 32'h0, r, adel, ades);
        check("sb_merge_readback", r, 32'h1122_AB44);
        do_req(3'd5, 32'h22, 32'h0000_00CD, r, adel, ades);
        do_req(3'd6, 32'h20, 32'h1234_5678, r, adel, ades);
        do_req(3'd4, 32'h20, 32'h0, r, adel, ades);
        check("sb_sh_chain", r, 32'h11CD_5678);

        do_req(3'd6, 32'h23, 32'hFFFF, r, adel, ades);
        check("sh_misalign_ades", 32'(ades), 32'd1);
        do_req(3'd4, 32'h0004_0000, 32'h0, r, adel, ades);
        check("lw_range_adel", 32'(adel), 32'd1);
        do_req(3'd4, 32'hFFFF_FFFC, 32'h0, r, adel, ades);
        check("lw_wrap_adel", 32'(adel), 32'd1);
        do_req(3'd7, 32'h0003_FFFC, 32'hCAFE_F00D, r, adel, ades);
        do_req(3'd4, 32'h0003_FFFC, 32'h0, r, adel, ades);
        check("lw_last_word", r, 32'hCAFE_F00D);

        // Two requests with req_valid held high throughout.
        model(3'd4, 32'h50, 32'h0, e_adel, e_ades, e1, e_lat, e_nwe, e_w);
        model(3'd4, 32'h54, 32'h0, e_adel, e_ades, e2, e_lat, e_nwe, e_w);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h50; req_wdata = '0;
        @(posedge clk);
        #1 req_addr = 32'h54;
        rv_seen = '0; rdy_seen = '0; r1 = '0; r2 = '0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            rv_seen[c]  = resp_valid;
            rdy_seen[c] = req_ready;
            if (c == 2) r1 = resp_rdata;
            if (c == 5) r2 = resp_rdata;
            if (c == 3) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        check("queued_resp_valid", 32'(rv_seen), 32'h24);
        check("queued_req_ready", 32'(rdy_seen), 32'hC8);
        check("queued_first_rdata", r1, e1);
        check("queued_second_rdata", r2, e2);

        for (int n = 0; n < 150; n++) begin
            op  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 15);
            case (sel)
                0:       addr = 32'h0004_0000 + $urandom_range(0, 255);
                1:       addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                2:       addr = 32'h0003_FFFC + 32'($urandom_range(0, 3));
                default: addr = 32'($urandom_range(0, 127));
            endcase
            do_req(op, addr, $urandom, r, adel, ades);
        end

        // Reset pulled low while an SB sits in WRITE.
        poke(16'd12, 32'h5566_7788);
        poke(16'd13, 32'hFFFF_0000);
        do_req(3'd4, 32'h34, 32'h0, r, adel, ades);
        check("pre_reset_rdata", r, 32'hFFFF_0000);
        req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h31; req_wdata = 32'hCD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("write_state_we", 32'(ram_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_we_drop", 32'(ram_we), 32'd0);
        check("async_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_reset_outputs("mid_reset");
        check("aborted_sb_word", ram_word(16'd12), 32'h5566_7788);
        do_req(3'd4, 32'h30, 32'h0, r, adel, ades);
        check("post_reset_lw", r, 32'h5566_7788);

        bad = 0;
        for (int i = 0; i < 65536; i++)
            if (ram_word(16'(i)) !== ref_mem[i]) bad++;
        check("ram_sweep_mismatches", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the CPU's MEM stage and `data_RAM`. It takes one byte, halfword or word access request and checks alignment and address range. It drives the word-only RAM port and returns sign- or zero-extended load data. Sub-word stores use a two-step read-modify-write, because the RAM has a single word-wide write enable and reads combinationally.

## Interface
- `ADDRESS_INITIAL`, 32'h00000000: base byte address of the data RAM window.
- `MEM_BYTES`, 32'h00040000: window size in bytes (65536 words, matches the RAM's 16-bit word index).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req_valid`  in  1  core presents an access.
- `req_ready`  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `req_op`  in  3  LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_adel`  out  1  address error on a load.
- `resp_ades`  out  1  address error on a store.
- `ram_we`  out  1  to `data_RAM.we`.
- `ram_addr`  out  32  to `data_RAM.data_address`; always `{addr_q[31:2],2'b00}`.
- `ram_wdata`  out  32  to `data_RAM.data`.
- `ram_rdata`  in  32  from `data_RAM.res`; combinational read.

## Operation
- **Byte order:** little-endian. Byte lane k = `addr[1:0]` occupies bits [8k+7:8k]. Halfword lane = `addr[1]` occupies bits [16h+15:16h].
- **Fault check, at acceptance:**
  - Misaligned: LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]!=0`.
  - Out of range: `(addr - ADDRESS_INITIAL)` ≥ `MEM_BYTES`. The subtraction is 32-bit unsigned, so addresses below the base wrap and also fault.
  - Misalignment and out-of-range both raise the same flag: `resp_adel` for ops 0–4, `resp_ades` for ops 5–7.
- **States:** IDLE, ACCESS, WRITE, RESP.
  - IDLE: `req_ready=1`. On acceptance, latch op, addr and wdata into `op_q`, `addr_q`, `wdata_q`. Go to RESP with the fault flag set if the check fails, otherwise go to ACCESS.
  - ACCESS:
    - Load: register the extended lane of `ram_rdata` into `resp_rdata`, then go to RESP.
    - SW: `ram_we=1`, `ram_wdata=wdata_q`, then go to RESP.
    - SB/SH: register `merge_q` = `ram_rdata` with the target lane replaced by `wdata_q[7:0]` or `wdata_q[15:0]`, then go to WRITE.
  - WRITE: `ram_we=1`, `ram_wdata=merge_q`, then go to RESP.
  - RESP: `resp_valid=1`, `req_ready=0`, then go to IDLE.
- **Extension:** LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- **Write safety:** `ram_we` is decoded from state and `op_q` only. It is never high in IDLE or RESP, or for a faulted request.
- `resp_rdata`, `resp_adel` and `resp_ades` are updated at entry to RESP. They hold until the next request reaches RESP. At entry to RESP, a store or fault sets `resp_rdata` to 0, and the fault flag not raised is cleared.

## Timing
- Acceptance at edge T0. `resp_valid` is high during:
  - cycle T2 for loads and SW;
  - cycle T3 for SB/SH;
  - cycle T1 for faults.
- The RAM write commits at the clock edge that ends ACCESS (SW) or WRITE (SB/SH).
- Throughput: at most one request per 3 cycles, or per 4 for sub-word stores. A `req_valid` arriving while `req_ready=0` is ignored, and the core must hold it.
- **Reset values:** state=IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_adel=0`, `resp_ades=0`, `ram_we=0`, `addr_q=0`, `wdata_q=0`, `merge_q=0`.
- **Reset mid-operation:** asserting `rst_n` low drops `ram_we` immediately, without waiting for a clock. An in-flight SB/SH during reset may leave RAM unmodified but never partially merged, since the only write is the full merged word.
- Back-to-back SB to the same word: the second request's ACCESS reads the first request's committed value.

## Structure
- Shared package `mem_access_pkg` holds:
  - the op-code constants (LB..SW);
  - the state encoding (2 bits);
  - the `is_store(op)` and `op_size(op)` helper constants or functions.
- One combinational sub-module, `mem_lane_align`, with inputs op, `addr[1:0]`, `ram_rdata` and wdata. It produces:
  - the extended load word;
  - the merged store word;
  - the misalignment flag.
- The FSM, registers and range check stay in `mem_access_unit`. Target size is about 180 lines of RTL.

## Test plan
- LW, addr 0x00000010, RAM word 0xDEADBEEF → `resp_valid` at T2, `resp_rdata=0xDEADBEEF`, no fault, `ram_we` never high.
- LB/LBU, addr 0x00000013, word 0x80112233 → LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SB, addr 0x00000021, wdata 0x000000AB, word 0x11223344 → one `ram_we` pulse in WRITE with `ram_wdata=0x1122AB44`, `resp_valid` at T3. A subsequent LW returns 0x1122AB44.
- SH, addr 0x00000023 → `resp_ades=1` at T1, `ram_we` stays 0 throughout. LW at 0x00040000 or at 0xFFFFFFFC → `resp_adel=1`.
- Hold `req_valid` high with two queued requests → second accepted only in the IDLE cycle following RESP. Exactly one `resp_valid` per request.
- Pull `rst_n` low mid-cycle in WRITE of an SB → `ram_we` falls asynchronously and the RAM word is unchanged. After release, `req_ready=1` and all outputs are at their reset values.
